// File: rtl/umi_reghost.sv
// umi_reghost
// Host-side register initiator. Turns a one-outstanding register access port
// into single-beat UMI request packets (read, acknowledged write, posted
// write), waits for the matching UMI response and returns read data, the
// response error code, or a timeout indication to the register side.
//
// Ports:
//   clk, nreset          clock, asynchronous active-low reset
//   reg_valid/reg_ready  register access handshake (ready only when idle)
//   reg_write/reg_posted access type (posted only meaningful with write)
//   reg_addr/reg_size    target address and UMI size code
//   reg_wrdata           write data (zero-extended into the UMI data bus)
//   reg_done             one-cycle completion pulse
//   reg_rddata           read data, held until the next read completion
//   reg_err/reg_timeout  completion status, valid with reg_done
//   uhost_req_*          UMI request channel (registered outputs)
//   uhost_resp_*         UMI response channel (never backpressured)

module umi_reghost #(
  parameter int             AW      = 64,
  parameter int             CW      = 32,
  parameter int             DW      = 256,
  parameter int             RW      = 64,
  parameter logic [AW-1:0]  SRCADDR = {AW{1'b0}},
  parameter logic [4:0]     HOSTID  = 5'd0,
  parameter int             TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          nreset,
  // register access port
  input  logic          reg_valid,
  output logic          reg_ready,
  input  logic          reg_write,
  input  logic          reg_posted,
  input  logic [AW-1:0] reg_addr,
  input  logic [2:0]    reg_size,
  input  logic [RW-1:0] reg_wrdata,
  output logic          reg_done,
  output logic [RW-1:0] reg_rddata,
  output logic [1:0]    reg_err,
  output logic          reg_timeout,
  // UMI request
  output logic          uhost_req_valid,
  input  logic          uhost_req_ready,
  output logic [CW-1:0] uhost_req_cmd,
  output logic [AW-1:0] uhost_req_dstaddr,
  output logic [AW-1:0] uhost_req_srcaddr,
  output logic [DW-1:0] uhost_req_data,
  // UMI response
  input  logic          uhost_resp_valid,
  output logic          uhost_resp_ready,
  input  logic [CW-1:0] uhost_resp_cmd,
  input  logic [AW-1:0] uhost_resp_dstaddr,
  input  logic [AW-1:0] uhost_resp_srcaddr,
  input  logic [DW-1:0] uhost_resp_data
);

  // UMI opcodes
  localparam logic [4:0] REQ_READ   = 5'h01;
  localparam logic [4:0] RESP_READ  = 5'h02;
  localparam logic [4:0] REQ_WRITE  = 5'h03;
  localparam logic [4:0] RESP_WRITE = 5'h04;
  localparam logic [4:0] REQ_POSTED = 5'h05;

  // Timeout fires when the wait counter sits at TIMEOUT-1 without a match.
  localparam logic        TO_EN   = (TIMEOUT != 0) ? 1'b1 : 1'b0;
  localparam logic [31:0] TO_LAST = (TIMEOUT != 0) ? 32'(TIMEOUT - 1) : 32'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // UMI command field layout:
  //   [4:0] opcode, [7:5] size, [15:8] len, [19:16] qos, [21:20] prot,
  //   [22] eom, [23] eof, [24] ex, [26:25] user/err, [31:27] hostid
  function automatic logic [CW-1:0] umi_pack(
    input logic [4:0] opcode,
    input logic [2:0] size,
    input logic [7:0] len,
    input logic [3:0] qos,
    input logic [1:0] prot,
    input logic       eom,
    input logic       eof,
    input logic       ex,
    input logic [1:0] user,
    input logic [4:0] hostid
  );
    logic [CW-1:0] cmd;
    cmd        = {CW{1'b0}};
    cmd[4:0]   = opcode;
    cmd[7:5]   = size;
    cmd[15:8]  = len;
    cmd[19:16] = qos;
    cmd[21:20] = prot;
    cmd[22]    = eom;
    cmd[23]    = eof;
    cmd[24]    = ex;
    cmd[26:25] = user;
    cmd[31:27] = hostid;
    return cmd;
  endfunction

  state_t        state_r;
  logic          is_read_r;
  logic          is_posted_r;
  logic [31:0]   timer_r;

  logic [4:0]    req_opcode_s;
  logic [CW-1:0] req_cmd_s;
  logic [DW-1:0] req_data_s;
  logic [4:0]    exp_opcode_s;
  logic          match_s;
  logic          expire_s;
  logic          unused_s;

  assign reg_ready        = (state_r == ST_IDLE);
  assign uhost_resp_ready = 1'b1;

  // Response fields this block never inspects.
  assign unused_s = ^{uhost_resp_srcaddr, uhost_resp_data, uhost_resp_cmd};

  // Request command and data built from the incoming access.
  always_comb begin
    req_opcode_s = REQ_READ;
    req_data_s   = {DW{1'b0}};
    if (reg_write) begin
      req_data_s[RW-1:0] = reg_wrdata;
      if (reg_posted) begin
        req_opcode_s = REQ_POSTED;
      end else begin
        req_opcode_s = REQ_WRITE;
      end
    end else begin
      req_opcode_s = REQ_READ;
    end
    req_cmd_s = umi_pack(req_opcode_s, reg_size, 8'd0, 4'd0, 2'd0,
                         1'b1, 1'b1, 1'b0, 2'd0, HOSTID);
  end

  // Response matching and timeout expiry for the outstanding request.
  always_comb begin
    if (is_read_r) begin
      exp_opcode_s = RESP_READ;
    end else begin
      exp_opcode_s = RESP_WRITE;
    end
    match_s  = uhost_resp_valid &&
               (uhost_resp_cmd[4:0] == exp_opcode_s) &&
               (uhost_resp_dstaddr == SRCADDR);
    expire_s = TO_EN && (timer_r == TO_LAST);
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r           <= ST_IDLE;
      is_read_r         <= 1'b0;
      is_posted_r       <= 1'b0;
      timer_r           <= 32'd0;
      uhost_req_valid   <= 1'b0;
      uhost_req_cmd     <= {CW{1'b0}};
      uhost_req_dstaddr <= {AW{1'b0}};
      uhost_req_srcaddr <= {AW{1'b0}};
      uhost_req_data    <= {DW{1'b0}};
      reg_done          <= 1'b0;
      reg_rddata        <= {RW{1'b0}};
      reg_err           <= 2'b00;
      reg_timeout       <= 1'b0;
    end else begin
      reg_done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (reg_valid) begin
            is_read_r         <= ~reg_write;
            is_posted_r       <= reg_write & reg_posted;
            uhost_req_cmd     <= req_cmd_s;
            uhost_req_dstaddr <= reg_addr;
            uhost_req_srcaddr <= SRCADDR;
            uhost_req_data    <= req_data_s;
            uhost_req_valid   <= 1'b1;
            state_r           <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (uhost_req_ready) begin
            uhost_req_valid <= 1'b0;
            timer_r         <= 32'd0;
            if (is_posted_r) begin
              reg_done    <= 1'b1;
              reg_err     <= 2'b00;
              reg_timeout <= 1'b0;
              state_r     <= ST_IDLE;
            end else begin
              state_r <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // A match wins over an expiry on the same cycle.
          if (match_s) begin
            reg_done    <= 1'b1;
            reg_err     <= uhost_resp_cmd[26:25];
            reg_timeout <= 1'b0;
            if (is_read_r) begin
              reg_rddata <= uhost_resp_data[RW-1:0];
            end
            state_r <= ST_IDLE;
          end else if (expire_s) begin
            reg_done    <= 1'b1;
            reg_err     <= 2'b11;
            reg_timeout <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            timer_r <= timer_r + 32'd1;
          end
        end
        default: begin
          uhost_req_valid <= 1'b0;
          state_r         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_umi_reghost.sv
// Self-checking bench for umi_reghost: a table of directed transactions plus
// hand-written sequences for back-to-back acceptance, dropped responses,
// timeout priority, late responses and reset in the middle of a wait.

module tb_umi_reghost;

  localparam logic [63:0] SRC = 64'h0000_0000_00AB_0000;

  logic          clk;
  logic          nreset;
  logic          reg_valid;
  logic          reg_ready;
  logic          reg_write;
  logic          reg_posted;
  logic [63:0]   reg_addr;
  logic [2:0]    reg_size;
  logic [63:0]   reg_wrdata;
  logic          reg_done;
  logic [63:0]   reg_rddata;
  logic [1:0]    reg_err;
  logic          reg_timeout;
  logic          uhost_req_valid;
  logic          uhost_req_ready;
  logic [31:0]   uhost_req_cmd;
  logic [63:0]   uhost_req_dstaddr;
  logic [63:0]   uhost_req_srcaddr;
  logic [255:0]  uhost_req_data;
  logic          uhost_resp_valid;
  logic          uhost_resp_ready;
  logic [31:0]   uhost_resp_cmd;
  logic [63:0]   uhost_resp_dstaddr;
  logic [63:0]   uhost_resp_srcaddr;
  logic [255:0]  uhost_resp_data;

  int tests_run;
  int tests_failed;

  umi_reghost #(
    .AW(64), .CW(32), .DW(256), .RW(64),
    .SRCADDR(SRC), .HOSTID(5'd3), .TIMEOUT(16)
  ) dut (
    .clk(clk), .nreset(nreset),
    .reg_valid(reg_valid), .reg_ready(reg_ready),
    .reg_write(reg_write), .reg_posted(reg_posted),
    .reg_addr(reg_addr), .reg_size(reg_size), .reg_wrdata(reg_wrdata),
    .reg_done(reg_done), .reg_rddata(reg_rddata),
    .reg_err(reg_err), .reg_timeout(reg_timeout),
    .uhost_req_valid(uhost_req_valid), .uhost_req_ready(uhost_req_ready),
    .uhost_req_cmd(uhost_req_cmd), .uhost_req_dstaddr(uhost_req_dstaddr),
    .uhost_req_srcaddr(uhost_req_srcaddr), .uhost_req_data(uhost_req_data),
    .uhost_resp_valid(uhost_resp_valid), .uhost_resp_ready(uhost_resp_ready),
    .uhost_resp_cmd(uhost_resp_cmd), .uhost_resp_dstaddr(uhost_resp_dstaddr),
    .uhost_resp_srcaddr(uhost_resp_srcaddr), .uhost_resp_data(uhost_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          write;
    logic          posted;
    logic [63:0]   addr;
    logic [2:0]    size;
    logic [63:0]   wrdata;
    int            stall;
    int            resp_delay;
    logic          noresp;
    logic [31:0]   resp_cmd;
    logic [255:0]  resp_data;
    logic [31:0]   exp_cmd;
    logic [63:0]   exp_rddata;
    logic [1:0]    exp_err;
    logic          exp_to;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a read and complete the request handshake; returns in WAIT cycle 1.
  task automatic start_read(input logic [63:0] addr);
    reg_valid = 1'b1; reg_write = 1'b0; reg_posted = 1'b0;
    reg_addr = addr; reg_size = 3'd3; reg_wrdata = 64'd0;
    step();
    reg_valid = 1'b0;
    uhost_req_ready = 1'b1;
    step();
    uhost_req_ready = 1'b0;
  endtask

  // Present one response beat for one cycle.
  task automatic send_resp(input logic [31:0] cmd, input logic [63:0] dst, input logic [255:0] data);
    uhost_resp_valid = 1'b1; uhost_resp_cmd = cmd;
    uhost_resp_dstaddr = dst; uhost_resp_data = data;
    chk("resp_ready", uhost_resp_ready, 1'b1);
    step();
    uhost_resp_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [255:0] exp_data;
    exp_data = v.write ? {192'd0, v.wrdata} : 256'd0;
    chk("ready_idle", reg_ready, 1'b1);
    reg_valid = 1'b1; reg_write = v.write; reg_posted = v.posted;
    reg_addr = v.addr; reg_size = v.size; reg_wrdata = v.wrdata;
    step();
    reg_valid = 1'b0;
    chk("req_valid", uhost_req_valid, 1'b1);
    chk("req_cmd", uhost_req_cmd, v.exp_cmd);
    chk("req_dst", uhost_req_dstaddr, v.addr);
    chk("req_src", uhost_req_srcaddr, SRC);
    chk("req_data", uhost_req_data, exp_data);
    chk("ready_busy", reg_ready, 1'b0);
    for (int i = 0; i < v.stall; i++) begin
      step();
      chk("stall_valid", uhost_req_valid, 1'b1);
      chk("stall_cmd", uhost_req_cmd, v.exp_cmd);
      chk("stall_dst", uhost_req_dstaddr, v.addr);
      chk("stall_data", uhost_req_data, exp_data);
    end
    uhost_req_ready = 1'b1;
    step();
    uhost_req_ready = 1'b0;
    chk("req_valid_drop", uhost_req_valid, 1'b0);
    if (!v.posted) begin
      if (v.noresp) begin
        for (int i = 0; i < 16; i++) begin
          chk("to_no_done", reg_done, 1'b0);
          step();
        end
      end else begin
        for (int i = 0; i < v.resp_delay; i++) begin
          chk("wait_no_done", reg_done, 1'b0);
          step();
        end
        send_resp(v.resp_cmd, SRC, v.resp_data);
      end
    end
    chk("done", reg_done, 1'b1);
    chk("rddata", reg_rddata, v.exp_rddata);
    chk("err", reg_err, v.exp_err);
    chk("timeout", reg_timeout, v.exp_to);
    chk("ready_at_done", reg_ready, 1'b1);
    step();
    chk("done_pulse", reg_done, 1'b0);
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    nreset = 1'b0;
    reg_valid = 1'b0; reg_write = 1'b0; reg_posted = 1'b0;
    reg_addr = 64'd0; reg_size = 3'd0; reg_wrdata = 64'd0;
    uhost_req_ready = 1'b0;
    uhost_resp_valid = 1'b0; uhost_resp_cmd = 32'd0;
    uhost_resp_dstaddr = 64'd0; uhost_resp_srcaddr = 64'd0; uhost_resp_data = 256'd0;

    // Command words: hostid 3 -> 0x18000000, eof|eom -> 0x00C00000.
    vecs[0] = '{write:1'b0, posted:1'b0, addr:64'h1000, size:3'd3, wrdata:64'd0,
                stall:0, resp_delay:3, noresp:1'b0, resp_cmd:32'h0000_0002,
                resp_data:256'hFFFF_0000_1111_2222_0123_4567_89AB_CDEF_DEAD_BEEF_CAFE_F00D,
                exp_cmd:32'h18C0_0061, exp_rddata:64'hDEAD_BEEF_CAFE_F00D,
                exp_err:2'b00, exp_to:1'b0};
    vecs[1] = '{write:1'b1, posted:1'b0, addr:64'h20, size:3'd0, wrdata:64'h55,
                stall:4, resp_delay:1, noresp:1'b0, resp_cmd:32'h0200_0004,
                resp_data:256'h1234,
                exp_cmd:32'h18C0_0003, exp_rddata:64'hDEAD_BEEF_CAFE_F00D,
                exp_err:2'b01, exp_to:1'b0};
    vecs[2] = '{write:1'b1, posted:1'b1, addr:64'h3000, size:3'd2, wrdata:64'h1122_3344_5566_7788,
                stall:0, resp_delay:0, noresp:1'b0, resp_cmd:32'd0, resp_data:256'd0,
                exp_cmd:32'h18C0_0045, exp_rddata:64'hDEAD_BEEF_CAFE_F00D,
                exp_err:2'b00, exp_to:1'b0};
    vecs[3] = '{write:1'b0, posted:1'b0, addr:64'h40, size:3'd2, wrdata:64'hFFFF,
                stall:1, resp_delay:0, noresp:1'b0, resp_cmd:32'h0400_0002,
                resp_data:256'h8765_4321,
                exp_cmd:32'h18C0_0041, exp_rddata:64'h0000_0000_8765_4321,
                exp_err:2'b10, exp_to:1'b0};
    vecs[4] = '{write:1'b0, posted:1'b0, addr:64'h5000, size:3'd3, wrdata:64'd0,
                stall:0, resp_delay:0, noresp:1'b1, resp_cmd:32'd0, resp_data:256'd0,
                exp_cmd:32'h18C0_0061, exp_rddata:64'h0000_0000_8765_4321,
                exp_err:2'b11, exp_to:1'b1};
    vecs[5] = '{write:1'b1, posted:1'b0, addr:64'hFFFF_0000_0000_0008, size:3'd3,
                wrdata:64'hA5A5_5A5A_0F0F_F0F0,
                stall:2, resp_delay:2, noresp:1'b0, resp_cmd:32'h0600_0004,
                resp_data:256'h9999,
                exp_cmd:32'h18C0_0063, exp_rddata:64'h0000_0000_8765_4321,
                exp_err:2'b11, exp_to:1'b0};

    // Reset state
    step(); step();
    chk("rst_ready", reg_ready, 1'b1);
    chk("rst_req_valid", uhost_req_valid, 1'b0);
    chk("rst_done", reg_done, 1'b0);
    chk("rst_timeout", reg_timeout, 1'b0);
    chk("rst_err", reg_err, 2'b00);
    chk("rst_rddata", reg_rddata, 64'd0);
    chk("rst_cmd", uhost_req_cmd, 32'd0);
    chk("rst_dst", uhost_req_dstaddr, 64'd0);
    chk("rst_src", uhost_req_srcaddr, 64'd0);
    chk("rst_data", uhost_req_data, 256'd0);
    chk("rst_resp_ready", uhost_resp_ready, 1'b1);
    nreset = 1'b1;
    step();

    for (int k = 0; k < 6; k++) begin
      run_vec(vecs[k]);
    end

    // Posted write, then a read accepted in the reg_done cycle.
    reg_valid = 1'b1; reg_write = 1'b1; reg_posted = 1'b1;
    reg_addr = 64'h60; reg_size = 3'd3; reg_wrdata = 64'h77;
    step();
    reg_valid = 1'b0;
    uhost_req_ready = 1'b1;
    step();
    uhost_req_ready = 1'b0;
    chk("bb_done", reg_done, 1'b1);
    chk("bb_ready", reg_ready, 1'b1);
    reg_valid = 1'b1; reg_write = 1'b0; reg_posted = 1'b0;
    reg_addr = 64'h77; reg_size = 3'd1;
    step();
    reg_valid = 1'b0;
    chk("bb_no_double_done", reg_done, 1'b0);
    chk("bb_req_valid", uhost_req_valid, 1'b1);
    chk("bb_req_cmd", uhost_req_cmd, 32'h18C0_0021);
    chk("bb_req_dst", uhost_req_dstaddr, 64'h77);
    uhost_req_ready = 1'b1;
    step();
    uhost_req_ready = 1'b0;
    send_resp(32'h0000_0002, SRC, 256'h0BAD);
    chk("bb_rd_done", reg_done, 1'b1);
    chk("bb_rddata", reg_rddata, 64'h0BAD);

    // Wrong dstaddr and wrong opcode are dropped; only the correct one completes.
    step();
    start_read(64'h88);
    send_resp(32'h0000_0002, SRC + 64'd1, 256'h5555);
    chk("drop_dst_done", reg_done, 1'b0);
    chk("drop_dst_busy", reg_ready, 1'b0);
    send_resp(32'h0000_0004, SRC, 256'h6666);
    chk("drop_op_done", reg_done, 1'b0);
    send_resp(32'h0000_0002, SRC, 256'h1111_2222_3333_4444);
    chk("drop_ok_done", reg_done, 1'b1);
    chk("drop_ok_rddata", reg_rddata, 64'h1111_2222_3333_4444);
    chk("drop_ok_err", reg_err, 2'b00);

    // Match on the expiry cycle completes normally.
    step();
    start_read(64'h90);
    for (int i = 0; i < 15; i++) begin
      chk("prio_no_done", reg_done, 1'b0);
      step();
    end
    send_resp(32'h0200_0002, SRC, 256'h1234);
    chk("prio_done", reg_done, 1'b1);
    chk("prio_timeout", reg_timeout, 1'b0);
    chk("prio_err", reg_err, 2'b01);
    chk("prio_rddata", reg_rddata, 64'h1234);

    // Timeout, then a late response is consumed without completion.
    step();
    start_read(64'hA0);
    for (int i = 0; i < 16; i++) begin
      chk("late_no_done", reg_done, 1'b0);
      step();
    end
    chk("late_to_done", reg_done, 1'b1);
    chk("late_to_flag", reg_timeout, 1'b1);
    chk("late_to_err", reg_err, 2'b11);
    chk("late_to_rddata", reg_rddata, 64'h1234);
    for (int i = 0; i < 5; i++) step();
    send_resp(32'h0000_0002, SRC, 256'h9999);
    chk("late_resp_done", reg_done, 1'b0);
    step();
    chk("late_resp_done2", reg_done, 1'b0);
    chk("late_rddata", reg_rddata, 64'h1234);

    // Reset while waiting for a response.
    start_read(64'hB0);
    step();
    chk("mid_busy", reg_ready, 1'b0);
    nreset = 1'b0;
    #1;
    chk("mid_ready", reg_ready, 1'b1);
    chk("mid_req_valid", uhost_req_valid, 1'b0);
    chk("mid_done", reg_done, 1'b0);
    chk("mid_rddata", reg_rddata, 64'd0);
    chk("mid_cmd", uhost_req_cmd, 32'd0);
    chk("mid_dst", uhost_req_dstaddr, 64'd0);
    step();
    nreset = 1'b1;
    step();
    send_resp(32'h0000_0002, SRC, 256'h4242);
    chk("mid_stray_done", reg_done, 1'b0);
    step();
    chk("mid_stray_done2", reg_done, 1'b0);
    chk("mid_stray_rddata", reg_rddata, 64'd0);
    chk("mid_idle", reg_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/umi_reghost.md
Name: umi_reghost

Overview:
- Host-side initiator that turns a simple one-outstanding register access port into UMI request packets, then returns read data and status to the register side.
- Sits on the host end of a UMI link, opposite a device-side register responder.
- Supports read, write (acknowledged) and posted write, each of at most RW bits and one beat (len=0).
- One transaction in flight at a time.

Parameters:
- AW, 64, address width
- CW, 32, UMI command width
- DW, 256, UMI data width
- RW, 64, register data width (RW <= DW)
- SRCADDR, 0, value driven on uhost_req_srcaddr; responses must carry this in dstaddr
- HOSTID, 0, 5-bit hostid field placed in request cmd
- TIMEOUT, 1024, response wait limit in cycles; 0 disables

Ports:
- clk  in  1  clock
- nreset  in  1  async active-low reset
- reg_valid  in  1  access request
- reg_ready  out  1  access accepted when reg_valid & reg_ready
- reg_write  in  1  1=write, 0=read
- reg_posted  in  1  with reg_write: posted write, no response awaited
- reg_addr  in  AW  target address
- reg_size  in  3  UMI size code (bytes = 2^size)
- reg_wrdata  in  RW  write data
- reg_done  out  1  1-cycle completion pulse
- reg_rddata  out  RW  read data, valid with reg_done, held until next completion
- reg_err  out  2  response err field, valid with reg_done
- reg_timeout  out  1  completion was a timeout, valid with reg_done
- uhost_req_valid/uhost_req_ready  out/in  1  UMI request handshake
- uhost_req_cmd  out  CW  request command
- uhost_req_dstaddr, uhost_req_srcaddr  out  AW  request addresses
- uhost_req_data  out  DW  request data
- uhost_resp_valid/uhost_resp_ready  in/out  1  UMI response handshake
- uhost_resp_cmd  in  CW  response command
- uhost_resp_dstaddr, uhost_resp_srcaddr  in  AW  response addresses
- uhost_resp_data  in  DW  response data

Behaviour:
Reset (clock clk; reset nreset, asynchronous, active-low):
- FSM=IDLE.
- uhost_req_valid, reg_done, reg_timeout = 0.
- reg_err, reg_rddata, uhost_req_cmd/dstaddr/srcaddr/data = 0.

Ready signals:
- reg_ready = (state==IDLE), combinational; therefore 1 out of reset.
- uhost_resp_ready = 1 always, so the block never backpressures responses.

IDLE:
- On reg_valid & reg_ready, capture the access into request registers:
  - dstaddr = reg_addr
  - srcaddr = SRCADDR
  - data = zero-extended reg_wrdata for writes; 0 for reads
- Command is built via umi_pack:
  - opcode = REQ_READ, REQ_WRITE or REQ_POSTED
  - size = reg_size, len = 0, eom = 1, eof = 1, hostid = HOSTID
  - all other fields 0
- Go to REQ; uhost_req_valid = 1 in the next cycle.

REQ:
- Hold uhost_req_valid and all request fields stable until uhost_req_ready.
- On the handshake cycle H, uhost_req_valid drops at H+1.
- Posted write: go to IDLE; reg_done=1 at H+1 with reg_err=0, reg_timeout=0.
- Otherwise: go to WAIT; clear the timeout counter.

WAIT:
- A matching response requires:
  - uhost_resp_valid = 1
  - opcode == RESP_READ for a read, RESP_WRITE for a write
  - uhost_resp_dstaddr == SRCADDR
- On a match at cycle R: go to IDLE; reg_done=1 at R+1; reg_err = response cmd err field.
- Reads additionally load reg_rddata = uhost_resp_data[RW-1:0].
- Non-matching responses are consumed and dropped with no state change.
- Timeout counter (32-bit) increments each WAIT cycle without a match.
- If TIMEOUT != 0 and the counter reaches TIMEOUT-1 without a match: go to IDLE; reg_done=1, reg_timeout=1, reg_err=2'b11; reg_rddata unchanged.
- A match on the same cycle as timeout expiry takes priority (normal completion).

Responses outside WAIT:
- Consumed and dropped, with no reg_done, including late responses after a timeout.

Completion-cycle rules:
- reg_done is a single-cycle pulse, never back-to-back.
- reg_ready is 1 in the reg_done cycle, so a new access can be accepted there.

Reset mid-operation:
- Abort immediately to IDLE with no reg_done.
- A later response to the aborted request is dropped.

Test Plan:
- Read at addr 0x1000, size 3; device answers RESP_READ with dstaddr=SRCADDR, data=0xDEADBEEF_CAFEF00D 3 cycles later -> one uhost_req with opcode REQ_READ, len 0; reg_done pulse 1 cycle after response; reg_rddata=0xDEADBEEFCAFEF00D, reg_err=0.
- Acknowledged write 0x55 to 0x20; uhost_req_ready low 4 cycles -> request fields stable for all 5 valid cycles; RESP_WRITE with err=2'b01 -> reg_done with reg_err=01; reg_rddata unchanged.
- Posted write, uhost_req_ready high -> reg_done 1 cycle after the handshake; no response awaited; next access accepted in the reg_done cycle.
- Read with TIMEOUT=16, no response -> reg_done after 16 WAIT cycles with reg_timeout=1, reg_err=11; a RESP_READ arriving 5 cycles later is accepted (ready=1) and produces no reg_done.
- In WAIT, inject RESP_READ with wrong dstaddr, then a correct one -> first dropped; completion only on the second.
- Assert nreset while in WAIT -> all outputs at reset values, reg_ready=1; a following stray response causes no reg_done.
